prog_feed16: RTL and testbench

- Instruction source for the 8-bit core, i.e. the supplying end of the core's 16-bit instruction input.
- Holds a small writable program buffer and a program counter.
- Presents the word at PC on `inst`; steps PC each time the core's fetch strobe (IR input enable) is high.
- Lets a host/testbench load a program, run it once or in a loop, and see completion.

---
 rtl/prog_feed16.sv | 133 +++++++++++++
 tb/tb_prog_feed16.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_feed16.sv
// prog_feed16 -- instruction source for the 8-bit core.
//
// Holds a small writable program buffer and a program counter. The word at
// pc is presented (registered) on inst. Each fetch strobe from the core
// advances pc. A host loads the program through the write port, starts it
// once or in a loop, and watches busy/done.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   wr_en      program write strobe (accepted in IDLE/DONE only)
//   wr_addr    program write address
//   wr_data    program write data
//   start      begin execution at address 0 (ignored while running)
//   abort      stop execution, return to IDLE (highest priority)
//   loop       sampled with start: wrap to 0 after the final word
//   last_addr  sampled with start: address of the final program word
//   fetch      core fetch strobe (core IR input enable)
//   inst       instruction to core, registered
//   pc         address of the word currently on inst
//   busy       high while running
//   done       sticky completion flag
//   wr_err     one-cycle pulse after a write attempted while running
module prog_feed16 #(
    parameter int unsigned AW       = 4,
    parameter logic [15:0] NOP_INST = 16'h7F0F
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic          start,
    input  logic          abort,
    input  logic          loop,
    input  logic [AW-1:0] last_addr,
    input  logic          fetch,
    output logic [15:0]   inst,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          wr_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] pc_n;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] end_addr, end_addr_n;
    logic          loop_r, loop_n;
    logic [15:0]   inst_n;
    logic          wr_err_n;
    logic          mem_we;

    logic [15:0]   mem [2**AW];

    // Buffer contents survive reset, so the array has no reset branch.
    assign mem_we = wr_en && (state != RUN);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign pc_inc = pc + 1'b1;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            inst     <= NOP_INST;
            wr_err   <= 1'b0;
            end_addr <= '0;
            loop_r   <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            inst     <= inst_n;
            wr_err   <= wr_err_n;
            end_addr <= end_addr_n;
            loop_r   <= loop_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        inst_n     = inst;
        end_addr_n = end_addr;
        loop_n     = loop_r;
        wr_err_n   = wr_en && (state == RUN);

        if (abort) begin
            state_n = IDLE;
            pc_n    = '0;
            inst_n  = NOP_INST;
        end else if (start && (state != RUN)) begin
            state_n    = RUN;
            pc_n       = '0;
            end_addr_n = last_addr;
            loop_n     = loop;
            // Word 0 being written on the same edge is forwarded so the
            // first instruction is never stale.
            if (wr_en && (wr_addr == '0)) begin
                inst_n = wr_data;
            end else begin
                inst_n = mem[0];
            end
        end else if ((state == RUN) && fetch) begin
            if (pc == end_addr) begin
                if (loop_r) begin
                    pc_n   = '0;
                    inst_n = mem[0];
                end else begin
                    state_n = DONE;
                    inst_n  = NOP_INST;
                end
            end else begin
                pc_n   = pc_inc;
                inst_n = mem[pc_inc];
            end
        end
    end

endmodule

// File: tb/tb_prog_feed16.sv
// tb_prog_feed16 -- self-checking bench for prog_feed16.
// Directed scenarios followed by randomized traffic, all compared each cycle
// against a behavioural model (program array + run/done flags + pc).
module tb_prog_feed16;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] NOP   = 16'h7F0F;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          loop = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic          fetch = 1'b0;
    logic [15:0]   inst;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          wr_err;

    prog_feed16 #(.AW(AW), .NOP_INST(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .abort     (abort),
        .loop      (loop),
        .last_addr (last_addr),
        .fetch     (fetch),
        .inst      (inst),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model
    logic [15:0] m_mem [DEPTH];
    bit          m_run, m_done, m_loop, m_wr_err;
    int          m_pc, m_end;

    logic [15:0] prog [3];
    logic [15:0] seq_nl [3];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_inst();
        return m_run ? m_mem[m_pc] : NOP;
    endfunction

    task automatic model_step();
        m_wr_err = wr_en && m_run;
        if (wr_en && !m_run) m_mem[wr_addr] = wr_data;
        if (abort) begin
            m_run = 0; m_done = 0; m_pc = 0;
        end else if (start && !m_run) begin
            m_run = 1; m_done = 0; m_pc = 0;
            m_end = int'(last_addr); m_loop = loop;
        end else if (m_run && fetch) begin
            if (m_pc == m_end) begin
                if (m_loop) m_pc = 0;
                else begin
                    m_run = 0; m_done = 1;
                end
            end else begin
                m_pc = (m_pc + 1) % DEPTH;
            end
        end
    endtask

    task automatic compare_all();
        check("inst",   inst,          exp_inst());
        check("pc",     16'(pc),       16'(m_pc));
        check("busy",   16'(busy),     16'(m_run));
        check("done",   16'(done),     16'(m_done));
        check("wr_err", 16'(wr_err),   16'(m_wr_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Reset is applied between edges and checked before any clock arrives.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_run = 0; m_done = 0; m_pc = 0; m_wr_err = 0;
        check("rst_inst", inst, NOP);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_pc",   16'(pc),   16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_werr", 16'(wr_err), 16'd0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        prog[0] = 16'hE105; prog[1] = 16'h0010; prog[2] = 16'h7F12;
        seq_nl[0] = 16'h0010; seq_nl[1] = 16'h7F12; seq_nl[2] = NOP;
        m_end = 0; m_loop = 0;

        #2;
        do_reset();

        // Fill whole buffer, then the test program.
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = 16'($urandom);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = prog[i];
            tick();
        end
        wr_en = 0;

        // One-shot run, fetch every other cycle.
        start = 1; last_addr = 2; loop = 0;
        tick();
        start = 0;
        check("start_inst", inst, 16'hE105);
        check("start_busy", 16'(busy), 16'd1);
        for (int k = 0; k < 3; k++) begin
            fetch = 1; tick();
            fetch = 0;
            check("oneshot_seq", inst, seq_nl[k]);
            tick();
        end
        check("oneshot_done", 16'(done), 16'd1);

        // Looping run, back-to-back fetches.
        start = 1; last_addr = 2; loop = 1;
        tick();
        start = 0; loop = 0;
        for (int i = 0; i < 7; i++) begin
            fetch = 1; tick();
            check("loop_seq", inst, prog[(i + 1) % 3]);
            check("loop_nodone", 16'(done), 16'd0);
        end
        fetch = 0;
        check("loop_pc", 16'(pc), 16'd1);

        // Write attempt while running.
        wr_en = 1; wr_addr = 1; wr_data = 16'hFFFF;
        tick();
        wr_en = 0;
        check("werr_hi", 16'(wr_err), 16'd1);
        tick();
        check("werr_lo", 16'(wr_err), 16'd0);
        for (int i = 0; i < 3; i++) begin
            fetch = 1; tick();
        end
        fetch = 0;
        check("werr_mem1", inst, 16'h0010);

        abort = 1; tick(); abort = 0;
        check("abort_busy", 16'(busy), 16'd0);

        // Start with simultaneous write to word 0.
        start = 1; wr_en = 1; wr_addr = 0; wr_data = 16'h2301; last_addr = 0; loop = 0;
        tick();
        start = 0; wr_en = 0;
        check("bypass_inst", inst, 16'h2301);
        check("bypass_busy", 16'(busy), 16'd1);
        fetch = 1; tick(); fetch = 0;
        check("single_done", 16'(done), 16'd1);
        check("single_inst", inst, NOP);

        // abort beats start in DONE.
        abort = 1; start = 1; last_addr = 2;
        tick();
        abort = 0; start = 0;
        check("abst_busy", 16'(busy), 16'd0);
        check("abst_done", 16'(done), 16'd0);
        check("abst_inst", inst, NOP);

        // start while running is ignored.
        start = 1; last_addr = 5; loop = 0;
        tick();
        start = 0;
        fetch = 1; tick(); fetch = 0;
        start = 1; tick(); start = 0;
        check("restart_pc",   16'(pc),   16'd1);
        check("restart_busy", 16'(busy), 16'd1);
        check("restart_inst", inst, 16'h0010);

        // Reset mid-run at pc=3; buffer must survive.
        fetch = 1; tick(); tick(); fetch = 0;
        check("mid_pc", 16'(pc), 16'd3);
        do_reset();
        start = 1; last_addr = 15; loop = 0;
        tick();
        start = 0;
        check("keep_mem0", inst, 16'h2301);
        fetch = 1; tick(); fetch = 0;
        check("keep_mem1", inst, 16'h0010);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            abort     = ($urandom_range(0, 99) < 3);
            start     = ($urandom_range(0, 99) < 8);
            wr_en     = ($urandom_range(0, 99) < 15);
            fetch     = ($urandom_range(0, 1) == 1);
            loop      = ($urandom_range(0, 1) == 1);
            last_addr = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom);
            wr_addr   = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom);
            wr_data   = 16'($urandom);
            tick();
        end
        abort = 0; start = 0; wr_en = 0; fetch = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
